// File: rtl/tournament_chooser.sv
// ============================================================================
// tournament_chooser
//   Tournament choice stage. A table of 2**IDX_W saturating choice counters
//   selects between the global and the local predictor for each lookup. The
//   selected direction is registered and presented one cycle after an
//   accepted lookup. Resolved branches train the counters toward whichever
//   predictor was correct. After reset an init sweep writes every entry to
//   WEAK_LOCAL. Lookups and updates are accepted only once ready_o is high.
//
// Parameters
//   IDX_W  choice-table index width (depth = 2**IDX_W)
//   CTR_W  choice-counter width (>= 2); counter MSB = 1 selects global
//
// Ports
//   clk_i               clock, rising edge
//   reset_i             synchronous reset, active-high
//   ready_o             init sweep complete
//   lookup_v_i          lookup request valid
//   lookup_idx_i        lookup index
//   global_pred_i       global predictor direction (same cycle as lookup)
//   local_pred_i        local predictor direction (same cycle as lookup)
//   pred_v_o            prediction valid, one cycle after accepted lookup
//   pred_o              selected direction (1 = taken)
//   pred_src_o          1 = global chosen, 0 = local chosen
//   update_v_i          training valid
//   update_idx_i        index to train
//   update_g_correct_i  global predictor was correct
//   update_l_correct_i  local predictor was correct
//
// Configuration macro
//   TOURN_CHOOSER_BYPASS_EN  when defined, a lookup to the index being
//                            updated in the same cycle sees the post-update
//                            counter; otherwise it sees the pre-update value.
// ============================================================================
module tournament_chooser #(
    parameter int IDX_W = 10,
    parameter int CTR_W = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    output logic             ready_o,
    input  logic             lookup_v_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    input  logic             global_pred_i,
    input  logic             local_pred_i,
    output logic             pred_v_o,
    output logic             pred_o,
    output logic             pred_src_o,
    input  logic             update_v_i,
    input  logic [IDX_W-1:0] update_idx_i,
    input  logic             update_g_correct_i,
    input  logic             update_l_correct_i
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX    = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN    = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] WEAK_LOCAL = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [IDX_W-1:0] LAST_IDX   = {IDX_W{1'b1}};

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CTR_W-1:0] ctr_q [DEPTH];

    logic             pred_v_q;
    logic             pred_q;
    logic             pred_src_q;

    logic             lookup_acc_s;
    logic             update_acc_s;
    logic [CTR_W-1:0] upd_cur_s;
    logic [CTR_W-1:0] upd_next_s;
    logic [CTR_W-1:0] lk_ctr_s;
    logic             lk_src_s;
    logic             lk_pred_s;

    // Saturating train step: move toward whichever predictor alone was right.
    function automatic logic [CTR_W-1:0] ctr_train(
        input logic [CTR_W-1:0] cur,
        input logic             g_ok,
        input logic             l_ok
    );
        logic [CTR_W-1:0] nxt;
        nxt = cur;
        if (g_ok && !l_ok) begin
            if (cur != CTR_MAX) nxt = cur + CTR_W'(1);
            else                nxt = cur;
        end else if (!g_ok && l_ok) begin
            if (cur != CTR_MIN) nxt = cur - CTR_W'(1);
            else                nxt = cur;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    // Next-state logic: INIT sweeps every entry once, then READY until reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == LAST_IDX) state_d = ST_READY;
                else                   state_d = ST_INIT;
            end
            ST_READY: begin
                state_d = ST_READY;
                ptr_d   = ptr_q;
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State and sweep-pointer registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_INIT;
            ptr_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Request acceptance, update next value and lookup selection.
    always_comb begin
        lookup_acc_s = (state_q == ST_READY) && lookup_v_i;
        update_acc_s = (state_q == ST_READY) && update_v_i;
        upd_cur_s    = ctr_q[update_idx_i];
        upd_next_s   = ctr_train(upd_cur_s, update_g_correct_i, update_l_correct_i);
`ifdef TOURN_CHOOSER_BYPASS_EN
        // Forward the counter being written this edge to a colliding lookup.
        if (update_acc_s && (update_idx_i == lookup_idx_i)) lk_ctr_s = upd_next_s;
        else                                               lk_ctr_s = ctr_q[lookup_idx_i];
`else
        // Read-before-write: a colliding lookup sees the old counter.
        lk_ctr_s = ctr_q[lookup_idx_i];
`endif
        lk_src_s  = lk_ctr_s[CTR_W-1];
        // When both predictors agree either choice yields the same direction.
        lk_pred_s = lk_src_s ? global_pred_i : local_pred_i;
    end

    // Choice table write port: init sweep or training update.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctr_q[0] <= ctr_q[0];
        end else if (state_q == ST_INIT) begin
            ctr_q[ptr_q] <= WEAK_LOCAL;
        end else if (update_acc_s) begin
            ctr_q[update_idx_i] <= upd_next_s;
        end else begin
            ctr_q[0] <= ctr_q[0];
        end
    end

    // Prediction output registers; direction and source hold between lookups.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pred_v_q   <= 1'b0;
            pred_q     <= 1'b0;
            pred_src_q <= 1'b0;
        end else begin
            pred_v_q <= lookup_acc_s;
            if (lookup_acc_s) begin
                pred_q     <= lk_pred_s;
                pred_src_q <= lk_src_s;
            end else begin
                pred_q     <= pred_q;
                pred_src_q <= pred_src_q;
            end
        end
    end

    assign ready_o    = (state_q == ST_READY);
    assign pred_v_o   = pred_v_q;
    assign pred_o     = pred_q;
    assign pred_src_o = pred_src_q;

endmodule

// File: tb/tb_tournament_chooser.sv
module tb_tournament_chooser;

    localparam int IDX_W = 10;
    localparam int CTR_W = 2;
    localparam int DEPTH = 2 ** IDX_W;
    localparam int CMAX  = (2 ** CTR_W) - 1;
    localparam int WEAK  = (2 ** (CTR_W - 1)) - 1;
    localparam int HALF  = 2 ** (CTR_W - 1);

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             ready_o;
    logic             lookup_v_i = 1'b0;
    logic [IDX_W-1:0] lookup_idx_i = '0;
    logic             global_pred_i = 1'b0;
    logic             local_pred_i = 1'b0;
    logic             pred_v_o;
    logic             pred_o;
    logic             pred_src_o;
    logic             update_v_i = 1'b0;
    logic [IDX_W-1:0] update_idx_i = '0;
    logic             update_g_correct_i = 1'b0;
    logic             update_l_correct_i = 1'b0;

    tournament_chooser #(.IDX_W(IDX_W), .CTR_W(CTR_W)) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .ready_o            (ready_o),
        .lookup_v_i         (lookup_v_i),
        .lookup_idx_i       (lookup_idx_i),
        .global_pred_i      (global_pred_i),
        .local_pred_i       (local_pred_i),
        .pred_v_o           (pred_v_o),
        .pred_o             (pred_o),
        .pred_src_o         (pred_src_o),
        .update_v_i         (update_v_i),
        .update_idx_i       (update_idx_i),
        .update_g_correct_i (update_g_correct_i),
        .update_l_correct_i (update_l_correct_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: counter values as plain integers, init progress as a count.
    int  model [DEPTH];
    int  init_cnt = 0;
    bit  ready_exp = 1'b0;
    int  total = 0;
    int  bad = 0;

    typedef struct packed { logic pred; logic src; } exp_t;
    exp_t exp_q [$];

    // One cycle: drive inputs at negedge, update the model for the coming edge.
    task automatic step(input bit rst, input bit lv, input int lidx, input bit g, input bit l,
                        input bit uv, input int uidx, input bit gc, input bit lc);
        int c;
        int unew;
        bit ready_now;
        exp_t e;
        @(negedge clk_i);
        reset_i            = rst;
        lookup_v_i         = lv;
        lookup_idx_i       = IDX_W'(lidx);
        global_pred_i      = g;
        local_pred_i       = l;
        update_v_i         = uv;
        update_idx_i       = IDX_W'(uidx);
        update_g_correct_i = gc;
        update_l_correct_i = lc;
        ready_now = ready_exp;
        if (rst) begin
            init_cnt  = 0;
            ready_exp = 1'b0;
            for (int i = 0; i < DEPTH; i++) model[i] = WEAK;
        end else begin
            unew = model[uidx];
            if (gc && !lc && unew < CMAX) unew = unew + 1;
            if (!gc && lc && unew > 0)    unew = unew - 1;
            if (ready_now && lv) begin
                c = model[lidx];
`ifdef TOURN_CHOOSER_BYPASS_EN
                if (uv && uidx == lidx) c = unew;
`endif
                e.src  = (c >= HALF);
                e.pred = e.src ? g : l;
                exp_q.push_back(e);
            end
            if (ready_now && uv) model[uidx] = unew;
            if (!ready_now) begin
                init_cnt = init_cnt + 1;
                if (init_cnt == DEPTH) ready_exp = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic rnd(input int n, input int maxidx);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom), int'($urandom_range(0, maxidx)), 1'($urandom), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, maxidx)), 1'($urandom), 1'($urandom));
    endtask

    // Monitor: after each edge compare ready, and pop/compare predictions.
    exp_t last = '0;
    always @(posedge clk_i) begin
        #1;
        if (reset_i) last = '0;
        total++;
        if (ready_o !== ready_exp) begin
            bad++;
            $display("FAIL ready: got %b expected %b at %0t", ready_o, ready_exp, $time);
        end
        if (pred_v_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pred_v: got pred_v=1 expected 0 at %0t", $time);
            end else begin
                last = exp_q.pop_front();
                if (pred_o !== last.pred || pred_src_o !== last.src) begin
                    bad++;
                    $display("FAIL pred: got pred=%b src=%b expected pred=%b src=%b at %0t",
                             pred_o, pred_src_o, last.pred, last.src, $time);
                end
            end
        end else begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                void'(exp_q.pop_front());
                $display("FAIL missing_pred: got pred_v=%b expected 1 at %0t", pred_v_o, $time);
            end else if (pred_o !== last.pred || pred_src_o !== last.src) begin
                bad++;
                $display("FAIL hold: got pred=%b src=%b expected pred=%b src=%b at %0t",
                         pred_o, pred_src_o, last.pred, last.src, $time);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = WEAK;
        // Reset, then the init sweep with random requests that must be ignored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0);
        rnd(DEPTH, DEPTH - 1);
        idle(2);
        // Weak-local lookup.
        step(1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        idle(1);
        // Saturate idx 5 toward global, then look up.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b0);
        step(1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        // Saturate idx 7 toward local, no wrap.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 7, 1'b0, 1'b1);
        step(1'b0, 1'b1, 7, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 7, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        // Same-cycle collision on idx 9, then back-to-back lookups.
        step(1'b0, 1'b1, 9, 1'b1, 1'b0, 1'b1, 9, 1'b1, 1'b0);
        step(1'b0, 1'b1, 9, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
        // Random traffic with dense collisions, then over the full table.
        rnd(1500, 15);
        rnd(500, DEPTH - 1);
        // Train idx 3 to max, reset mid-sweep at ptr 100, and check it reverts.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        rnd(100, 15);
        step(1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b0);
        rnd(DEPTH, 15);
        idle(1);
        step(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        rnd(300, 7);
        idle(3);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
